// File: rtl/regfile_scan_pkg.sv
// Shared defaults and FSM state type for the register-file change scanner.
package regfile_scan_pkg;

  localparam int unsigned NEntriesDef = 4;
  localparam int unsigned AwDef       = 2;
  localparam int unsigned DwDef       = 8;
  localparam int unsigned DivWDef     = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StSample,
    StEmit
  } state_e;

endpackage

// File: rtl/regfile_scan_shadow.sv
// Shadow copy of the scanned register file: one write port, valid bits cleared
// on reset, and a combinational "differs from last seen" flag for one entry.
module regfile_scan_shadow
  import regfile_scan_pkg::*;
#(
  parameter int unsigned N_ENTRIES = NEntriesDef,
  parameter int unsigned AW        = AwDef,
  parameter int unsigned DW        = DwDef
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  input  logic [DW-1:0] rdata_i,
  output logic          mismatch_o
);

  logic [DW-1:0]        shadow_q [N_ENTRIES];
  logic [N_ENTRIES-1:0] valid_q;

  // Shadow storage and valid bits; reset forgets every entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(N_ENTRIES); i++) begin
        shadow_q[i] <= '0;
      end
    end else if (we_i) begin
      valid_q[waddr_i]  <= 1'b1;
      shadow_q[waddr_i] <= wdata_i;
    end
  end

  // Never-seen entries count as changed.
  assign mismatch_o = !valid_q[raddr_i] || (shadow_q[raddr_i] != rdata_i);

endmodule

// File: rtl/regfile_scan.sv
// Round-robin scanner over a small register file that emits an (addr, data)
// record on a valid/ready stream whenever an entry differs from its shadow.
module regfile_scan
  import regfile_scan_pkg::*;
#(
  parameter int unsigned N_ENTRIES = NEntriesDef,
  parameter int unsigned AW        = AwDef,
  parameter int unsigned DW        = DwDef,
  parameter int unsigned DIV_W     = DivWDef
) (
  input  logic             CLKIN,
  input  logic             RESET,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             FORCE,
  output logic [AW-1:0]    RADDR,
  input  logic [DW-1:0]    RDATA,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [AW-1:0]    O_ADDR,
  output logic [DW-1:0]    O_DATA,
  output logic             SWEEP_DONE
);

  localparam logic [AW-1:0] LastAddr = AW'(N_ENTRIES - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic [AW-1:0]    o_addr_q, o_addr_d;
  logic [DW-1:0]    o_data_q, o_data_d;
  logic             o_valid_q, o_valid_d;
  logic             sweep_done_q, sweep_done_d;
  logic             force_req_q, force_req_d;
  logic             force_active_q, force_active_d;

  logic mismatch;
  logic at_first;
  logic at_last;
  logic force_eff;
  logic sampling;
  logic emit;
  logic retire;

  assign at_first = (raddr_q == '0);
  assign at_last  = (raddr_q == LastAddr);
  assign sampling = (state_q == StSample);

  // A force only takes hold at the start of a sweep so it always covers a full one.
  assign force_eff = at_first ? (force_req_q | FORCE) : force_active_q;
  assign emit      = sampling && (mismatch || force_eff);
  assign retire    = (sampling && !(mismatch || force_eff)) ||
                     ((state_q == StEmit) && o_valid_q && O_READY);

  regfile_scan_shadow #(
    .N_ENTRIES (N_ENTRIES),
    .AW        (AW),
    .DW        (DW)
  ) u_shadow (
    .clk_i      (CLKIN),
    .rst_i      (RESET),
    .we_i       (emit),
    .waddr_i    (raddr_q),
    .wdata_i    (RDATA),
    .raddr_i    (raddr_q),
    .rdata_i    (RDATA),
    .mismatch_o (mismatch)
  );

  // FSM state register.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (EN) state_d = StWait;
      StWait:   if (cnt_q == '0) state_d = StSample;
      StSample: begin
        if (emit) begin
          state_d = StEmit;
        end else begin
          state_d = EN ? StWait : StIdle;
        end
      end
      StEmit:   if (retire) state_d = EN ? StWait : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Pacing counter, address, force tracking and output record next values.
  always_comb begin
    cnt_d          = cnt_q;
    raddr_d        = raddr_q;
    o_valid_d      = o_valid_q;
    o_addr_d       = o_addr_q;
    o_data_d       = o_data_q;
    sweep_done_d   = 1'b0;
    force_req_d    = force_req_q | FORCE;
    force_active_d = force_active_q;

    if ((state_q == StIdle) && EN) begin
      cnt_d = DIV;
    end
    if ((state_q == StWait) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    // Sweep start consumes any pending request, including one arriving this cycle.
    if (sampling && at_first) begin
      force_req_d    = 1'b0;
      force_active_d = force_eff;
    end

    if (emit) begin
      o_valid_d = 1'b1;
      o_addr_d  = raddr_q;
      o_data_d  = RDATA;
    end

    if (retire) begin
      o_valid_d = 1'b0;
      cnt_d     = DIV;
      raddr_d   = at_last ? '0 : raddr_q + 1'b1;
      if (at_last) begin
        sweep_done_d   = 1'b1;
        force_active_d = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      cnt_q          <= '0;
      raddr_q        <= '0;
      o_valid_q      <= 1'b0;
      o_addr_q       <= '0;
      o_data_q       <= '0;
      sweep_done_q   <= 1'b0;
      force_req_q    <= 1'b0;
      force_active_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      raddr_q        <= raddr_d;
      o_valid_q      <= o_valid_d;
      o_addr_q       <= o_addr_d;
      o_data_q       <= o_data_d;
      sweep_done_q   <= sweep_done_d;
      force_req_q    <= force_req_d;
      force_active_q <= force_active_d;
    end
  end

  assign RADDR      = raddr_q;
  assign O_VALID    = o_valid_q;
  assign O_ADDR     = o_addr_q;
  assign O_DATA     = o_data_q;
  assign SWEEP_DONE = sweep_done_q;

endmodule

// File: tb/tb_regfile_scan.sv
// Scoreboard bench for regfile_scan: a sweep-level model predicts records,
// a monitor pops and compares on every accepted handshake.
module tb_regfile_scan;

  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DIV_W = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             force_p;
  logic             o_ready;
  logic [AW-1:0]    raddr;
  logic [DW-1:0]    rdata;
  logic             o_valid;
  logic [AW-1:0]    o_addr;
  logic [DW-1:0]    o_data;
  logic             sweep_done;

  logic [DW-1:0] rf [N];
  logic [DW-1:0] mshadow [N];
  bit            mvalid [N];
  rec_t          exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;

  assign rdata = rf[raddr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_scan #(
    .N_ENTRIES (N),
    .AW        (AW),
    .DW        (DW),
    .DIV_W     (DIV_W)
  ) dut (
    .CLKIN      (clk),
    .RESET      (rst),
    .EN         (en),
    .DIV        (div),
    .FORCE      (force_p),
    .RADDR      (raddr),
    .RDATA      (rdata),
    .O_VALID    (o_valid),
    .O_READY    (o_ready),
    .O_ADDR     (o_addr),
    .O_DATA     (o_data),
    .SWEEP_DONE (sweep_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One sweep from address 0: every changed, unseen or forced entry produces a record.
  task automatic plan_sweep(input bit frc);
    for (int a = 0; a < N; a++) begin
      if (frc || !mvalid[a] || mshadow[a] != rf[a]) begin
        exp_q.push_back({AW'(a), rf[a]});
      end
      mvalid[a]  = 1'b1;
      mshadow[a] = rf[a];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sweep_done && n < 2000);
    if (!sweep_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no SWEEP_DONE after %0d cycles", name, n);
    end else begin
      check({name, "_drain"}, exp_q.size(), 0);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_valid && n < 500);
    if (!o_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: O_VALID still 0 after %0d cycles", name, n);
    end
  endtask

  task automatic pulse_force();
    force_p = 1'b1;
    tick();
    force_p = 1'b0;
  endtask

  // Monitor: compares accepted records, checks stall stability and pulse width.
  rec_t          mon_e;
  bit            stalled = 1'b0;
  bit            prev_sd = 1'b0;
  logic [AW-1:0] hold_a, hold_r;
  logic [DW-1:0] hold_d;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
      prev_sd = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", o_valid, 1);
        check("stall_addr", o_addr, hold_a);
        check("stall_data", o_data, hold_d);
        check("stall_raddr", raddr, hold_r);
      end
      stalled = o_valid && !o_ready;
      hold_a  = o_addr;
      hold_d  = o_data;
      hold_r  = raddr;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_record: got (%0d,0x%0h), expected none", o_addr, o_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rec_addr", o_addr, mon_e.a);
          check("rec_data", o_data, mon_e.d);
        end
      end
      if (prev_sd) check("sweep_done_width", sweep_done, 0);
      prev_sd = sweep_done;
    end
  end

  // Random back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) o_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t_prev;

    rst     = 1'b1;
    en      = 1'b0;
    div     = '0;
    force_p = 1'b0;
    o_ready = 1'b1;
    rf[0] = 8'h01; rf[1] = 8'h02; rf[2] = 8'h03; rf[3] = 8'h00;
    for (int a = 0; a < N; a++) begin
      mvalid[a]  = 1'b0;
      mshadow[a] = '0;
    end
    repeat (3) tick();
    check("rst_raddr", raddr, 0);
    check("rst_valid", o_valid, 0);
    check("rst_oaddr", o_addr, 0);
    check("rst_odata", o_data, 0);
    check("rst_sweep_done", sweep_done, 0);
    rst = 1'b0;
    tick();

    // First sweep: every entry is unseen, records three cycles apart.
    plan_sweep(1'b0);
    en = 1'b1;
    t_prev = 0;
    for (int k = 0; k < N; k++) begin
      wait_valid("first_rec");
      if (k > 0) check("rec_spacing", cyc - t_prev, 3);
      t_prev = cyc;
    end
    wait_sweep("sweep1", n);
    check("sweep1_done_lag", n, 1);
    plan_sweep(1'b0);
    wait_sweep("quiet_a", n);
    check("quiet_period_a", n, 8);
    plan_sweep(1'b0);
    wait_sweep("quiet_b", n);
    check("quiet_period_b", n, 8);

    // Single change reported once.
    rf[2] = 8'h7F;
    plan_sweep(1'b0);
    wait_sweep("change", n);
    check("change_period", n, 9);
    plan_sweep(1'b0);
    wait_sweep("change_after", n);
    check("change_after_period", n, 8);

    // Back-pressure: record and address hold while stalled, no duplicate.
    rf[0] = 8'h11;
    plan_sweep(1'b0);
    o_ready = 1'b0;
    wait_valid("stall");
    repeat (5) tick();
    o_ready = 1'b1;
    wait_sweep("stall_sweep", n);
    plan_sweep(1'b0);
    wait_sweep("stall_after", n);
    check("stall_after_period", n, 8);

    // FORCE re-emits a full sweep exactly once.
    plan_sweep(1'b1);
    pulse_force();
    wait_sweep("force", n);
    plan_sweep(1'b0);
    wait_sweep("force_after", n);
    check("force_after_period", n, 8);

    // Pacing with DIV=3, then a mid-WAIT change to DIV=0.
    div = 16'd3;
    plan_sweep(1'b0);
    wait_sweep("div3_first", n);
    check("div3_first_period", n, 17);
    plan_sweep(1'b0);
    wait_sweep("div3", n);
    check("div3_period", n, 20);
    div = 16'd0;
    plan_sweep(1'b0);
    wait_sweep("div_switch", n);
    check("div_switch_period", n, 11);
    plan_sweep(1'b0);
    wait_sweep("div0", n);
    check("div0_period", n, 8);

    // EN dropped during a stalled EMIT: record completes, park at next address.
    rf[1] = 8'hA5;
    plan_sweep(1'b0);
    o_ready = 1'b0;
    wait_valid("park");
    en = 1'b0;
    repeat (5) tick();
    o_ready = 1'b1;
    tick();
    repeat (4) tick();
    check("park_raddr", raddr, 2);
    check("park_valid", o_valid, 0);
    check("park_sweep_done", sweep_done, 0);
    en = 1'b1;
    wait_sweep("resume", n);
    plan_sweep(1'b0);
    wait_sweep("resume_after", n);
    check("resume_after_period", n, 8);

    // RESET during EMIT drops the record and invalidates the shadow.
    rf[2] = 8'h3C;
    plan_sweep(1'b0);
    o_ready = 1'b0;
    wait_valid("rst_emit");
    rst = 1'b1;
    tick();
    check("rst_emit_valid", o_valid, 0);
    check("rst_emit_raddr", raddr, 0);
    exp_q.delete();
    for (int a = 0; a < N; a++) mvalid[a] = 1'b0;
    rst     = 1'b0;
    o_ready = 1'b1;
    plan_sweep(1'b0);
    wait_sweep("post_rst", n);
    plan_sweep(1'b0);
    wait_sweep("post_rst_after", n);
    check("post_rst_period", n, 8);

    // Randomized changes, forces, pacing and back-pressure.
    rand_ready = 1'b1;
    for (int s = 0; s < 30; s++) begin
      bit frc;
      for (int a = 0; a < N; a++) begin
        if ($urandom_range(0, 2) == 0) rf[a] = DW'($urandom);
      end
      div = DIV_W'($urandom_range(0, 3));
      frc = ($urandom_range(0, 4) == 0);
      plan_sweep(frc);
      if (frc) pulse_force();
      wait_sweep("rand", n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
